// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage plus IF/ID pipeline register.
//
// Holds the fetch PC and issues one outstanding request at a time on a
// req/gnt + rvalid instruction-memory interface. The returned word and its
// PC are presented to decode through the IF/ID register. A one-entry buffer
// absorbs a response that arrives while decode is stalled. Execute-stage
// redirects flush IF/ID and discard any response still in flight.
//
// Ports
//   clk, reset            core clock, asynchronous active-high reset
//   imem_req/imem_addr    fetch request and word-aligned byte address
//   imem_gnt              request accepted this cycle
//   imem_rvalid/rdata     in-order response, at least one cycle after grant
//   stall_d               decode cannot accept, IF/ID holds
//   redirect_e/target_e   taken branch/jump from execute and its target
//   instr_d/pc_d/
//   pc_plus4_d/valid_d    registered IF/ID contents presented to decode
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | request pc_f, advance on grant
// WAIT   | one request outstanding, waiting for rvalid
// HOLD   | response parked in the buffer until decode stops stalling
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_d,
    input  logic        redirect_e,
    input  logic [31:0] target_e,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        kill_q, kill_d;
    logic        slot_free;

    // Only combinational input path: a redirect suppresses the request in
    // the same cycle so the wrong-path address is never granted.
    assign imem_req   = (state_q == S_FETCH) && !redirect_e && !reset;
    assign imem_addr  = pc_f_q;
    assign slot_free  = !if_valid_q || !stall_d;

    assign instr_d    = if_instr_q;
    assign pc_d       = if_pc_q;
    assign pc_plus4_d = if_pc4_q;
    assign valid_d    = if_valid_q;

    always_comb begin
        state_d     = state_q;
        pc_f_d      = pc_f_q;
        req_pc_d    = req_pc_q;
        kill_d      = kill_q;
        if_instr_d  = if_instr_q;
        if_pc_d     = if_pc_q;
        if_pc4_d    = if_pc4_q;
        if_valid_d  = if_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;

        if (redirect_e) begin
            pc_f_d     = target_e & 32'hFFFF_FFFC;
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            case (state_q)
                S_WAIT: begin
                    if (imem_rvalid) begin
                        // Stale word arrives together with the redirect: drop it now.
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        // Response still in flight: remember to discard it.
                        kill_d  = 1'b1;
                    end
                end
                S_HOLD:  state_d = S_FETCH;
                S_FETCH: state_d = S_FETCH;
                default: state_d = S_FETCH;
            endcase
        end else begin
            // Decode consumed the current word; show a bubble unless a new one loads below.
            if (if_valid_q && !stall_d) begin
                if_valid_d = 1'b0;
                if_instr_d = NOP_INSTR;
            end
            case (state_q)
                S_FETCH: begin
                    if (imem_req && imem_gnt) begin
                        req_pc_d = pc_f_q;
                        pc_f_d   = pc_f_q + 32'd4;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_FETCH;
                        end else if (slot_free) begin
                            if_instr_d = imem_rdata;
                            if_pc_d    = req_pc_q;
                            if_pc4_d   = req_pc_q + 32'd4;
                            if_valid_d = 1'b1;
                            state_d    = S_FETCH;
                        end else begin
                            buf_instr_d = imem_rdata;
                            buf_pc_d    = req_pc_q;
                            state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_d) begin
                        if_instr_d = buf_instr_q;
                        if_pc_d    = buf_pc_q;
                        if_pc4_d   = buf_pc_q + 32'd4;
                        if_valid_d = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_f_q      <= RESET_PC;
            req_pc_q    <= 32'h0;
            kill_q      <= 1'b0;
            if_instr_q  <= NOP_INSTR;
            if_pc_q     <= 32'h0;
            if_pc4_q    <= 32'h4;
            if_valid_q  <= 1'b0;
            buf_instr_q <= 32'h0;
            buf_pc_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_f_q      <= pc_f_d;
            req_pc_q    <= req_pc_d;
            kill_q      <= kill_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
            if_pc4_q    <= if_pc4_d;
            if_valid_q  <= if_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: randomized memory/decode/execute environment,
// a program-order reference model and a scoreboard checked by a monitor.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        redirect_e;
    logic [31:0] target_e;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .stall_d    (stall_d),
        .redirect_e (redirect_e),
        .target_e   (target_e),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pc_plus4_d (pc_plus4_d),
        .valid_d    (valid_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          gcyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    exp_t        sb_q[$];
    mem_t        mem_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          gnt_pct = 100, stall_pct = 0, redir_pct = 0, lat_min = 0, lat_max = 0;
    int          stall_force = 0, rst_cycles = 3, gnt_off = 0, stale_cnt = 0;
    bit          dir_redirect = 1'b0;
    logic [31:0] dir_target = 32'h0;
    bit          tput_chk = 1'b0;
    logic [31:0] model_pc = RESET_PC;
    int          n_grants = 0, n_delivered = 0;
    bit          flush_chk = 1'b0;
    bit          prev_v = 1'b0, prev_s = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant();
        int g;
        g = n_grants;
        for (int i = 0; i < 60 && n_grants == g; i++) @(negedge clk);
        check("grant_timeout", (n_grants != g), 1);
    endtask

    // Environment driver: memory responses, grants, decode stalls, redirects.
    initial begin
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        stall_d = 1'b0; redirect_e = 1'b0; target_e = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            reset = (rst_cycles > 0);
            if (rst_cycles > 0) rst_cycles--;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_q[0].addr ^ KEY;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
            if (gnt_off > 0) begin
                imem_gnt = 1'b0;
                gnt_off--;
            end else begin
                // Memory stays busy until responses orphaned by a reset have drained.
                imem_gnt = (stale_cnt == 0) && ($urandom_range(0, 99) < gnt_pct);
            end
            if (stall_force > 0) begin
                stall_d = 1'b1;
                stall_force--;
            end else begin
                stall_d = ($urandom_range(0, 99) < stall_pct);
            end
            if (dir_redirect) begin
                redirect_e   = 1'b1;
                target_e     = dir_target;
                dir_redirect = 1'b0;
            end else begin
                redirect_e = ($urandom_range(0, 99) < redir_pct);
                target_e   = $urandom;
            end
        end
    end

    // Reference model: program-order fetch PC, memory timing, expected stream.
    initial begin
        int lat;
        forever begin
            @(negedge clk);
            #1;
            if (imem_rvalid && mem_q.size() > 0) begin
                void'(mem_q.pop_front());
                if (stale_cnt > 0) stale_cnt--;
            end
            if (reset) begin
                check("rst_ifid", {instr_d, pc_d, pc_plus4_d}, {NOP, 32'h0, 32'h4});
                check("rst_req", {imem_req, valid_d, imem_addr}, {1'b0, 1'b0, RESET_PC});
                sb_q.delete();
                model_pc  = RESET_PC;
                flush_chk = 1'b0;
                stale_cnt = mem_q.size();
            end else begin
                if (flush_chk) begin
                    check("flush", {valid_d, instr_d}, {1'b0, NOP});
                    flush_chk = 1'b0;
                end
                if (redirect_e) begin
                    check("req_gated", imem_req, 0);
                    sb_q.delete();
                    model_pc  = target_e & 32'hFFFF_FFFC;
                    flush_chk = 1'b1;
                end else if (imem_req && imem_gnt) begin
                    check("fetch_addr", imem_addr, model_pc);
                    // The previous word must have reached decode (or been discarded) first.
                    check("one_in_flight", sb_q.size(), 0);
                    lat = $urandom_range(lat_min, lat_max);
                    mem_q.push_back('{addr: imem_addr, due: cyc + 1 + lat});
                    sb_q.push_back('{pc: model_pc, gcyc: cyc});
                    model_pc = model_pc + 32'd4;
                    n_grants++;
                end
            end
        end
    end

    // Monitor: compares each newly presented IF/ID entry against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v = 1'b0;
                prev_s = 1'b0;
            end else begin
                if (valid_d && !(prev_v && prev_s)) begin
                    if (sb_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_instr: got pc %h instr %h, required no instruction", pc_d, instr_d);
                    end else begin
                        e = sb_q.pop_front();
                        check("ifid", {instr_d, pc_d, pc_plus4_d}, {e.pc ^ KEY, e.pc, e.pc + 32'd4});
                        n_delivered++;
                        if (tput_chk) check("latency", cyc - e.gcyc, 2);
                    end
                end
                if (!valid_d) check("nop_when_idle", instr_d, NOP);
                prev_v = valid_d;
                prev_s = stall_d;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        run(5);
        // Zero-wait memory: one instruction every two cycles, two-cycle latency.
        gnt_pct = 100; tput_chk = 1'b1;
        run(40);
        tput_chk = 1'b0;
        // Grant withheld for three cycles.
        gnt_off = 3;
        run(20);
        // Decode stall while a response arrives.
        stall_force = 5;
        run(20);
        // Redirect while a request is outstanding.
        lat_min = 2; lat_max = 2;
        wait_grant();
        dir_target = 32'h0000_0100; dir_redirect = 1'b1;
        run(20);
        // Redirect together with a stall while the buffer is full.
        lat_min = 0; lat_max = 0;
        wait_grant();
        stall_force = 10;
        run(7);
        dir_target = 32'h0000_0200; dir_redirect = 1'b1;
        run(20);
        // Address wrap; low target bits are ignored.
        dir_target = 32'hFFFF_FFFB; dir_redirect = 1'b1;
        run(15);
        // Reset while waiting, stale response arrives afterwards.
        lat_min = 4; lat_max = 4;
        wait_grant();
        rst_cycles = 1;
        run(25);
        // Randomized soak.
        lat_min = 0; lat_max = 3; gnt_pct = 60; stall_pct = 30; redir_pct = 3;
        run(3000);
        redir_pct = 0; stall_pct = 0; gnt_pct = 100;
        run(20);
        check("progress", (n_delivered >= 300), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
